// File: rtl/reset_sequencer_pkg.sv
// Shared types, constants and parameter checks for the reset sequencer.
package reset_seq_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    WAIT_ACK,
    GAP,
    READY
  } seq_state_e;

  // Width of the stage index bus; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when every parameter lies inside its supported range.
  function automatic bit params_ok(input int unsigned num_stages,
                                   input int unsigned hold_cycles,
                                   input int unsigned stage_delay,
                                   input int unsigned ack_timeout);
    return (num_stages  >= 1) && (num_stages  <= 16)  &&
           (hold_cycles >= 1) && (hold_cycles <= 255) &&
           (stage_delay >= 1) && (stage_delay <= 255) &&
           (ack_timeout >= 1) && (ack_timeout <= 255);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the stages it releases.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4
) ();

  localparam int unsigned IDX_W = idx_width(NUM_STAGES);

  logic                  sw_rst_req_i;
  logic [NUM_STAGES-1:0] stage_ack_i;
  logic [NUM_STAGES-1:0] rst_o;
  logic                  ready_o;
  logic                  busy_o;
  logic [IDX_W-1:0]      stage_idx_o;
  logic                  timeout_o;

  // Sequencer side
  modport master (
    input  sw_rst_req_i, stage_ack_i,
    output rst_o, ready_o, busy_o, stage_idx_o, timeout_o
  );

  // Downstream / software side
  modport slave (
    output sw_rst_req_i, stage_ack_i,
    input  rst_o, ready_o, busy_o, stage_idx_o, timeout_o
  );

endinterface

// File: rtl/reset_sequencer_reset_sync.sv
// Two-flop reset synchronizer: asserts with reset, deasserts on the 2nd clk edge after.
module reset_sync (
  input  logic clk,
  input  logic reset,
  output logic rst_sync_o
);

  logic [1:0] sync_q;

  // Shift zeros in once reset is gone; async set while it is present
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], 1'b0};
    end
  end

  assign rst_sync_o = sync_q[1];

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: holds all stage resets, then releases them in order,
// each release gated by the previous stage's ack (or an ack timeout).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STAGE_DELAY = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  reset_sequencer_if.master bus
);

  localparam int unsigned IDX_W = idx_width(NUM_STAGES);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STAGES - 1);

  if (!params_ok(NUM_STAGES, HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT)) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end

  logic rst_sync;

  reset_sync u_reset_sync (
    .clk       (clk),
    .reset     (reset),
    .rst_sync_o(rst_sync)
  );

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  tmo_q, tmo_d;
  logic                  ack_c;

  // Sequencer registers, reset by the synchronized internal reset
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ack_c = bus.stage_ack_i[idx_q];

  // Next-state: hold, release stage, wait for its ack, inter-stage gap, done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    tmo_d   = tmo_q;

    case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      RELEASE: begin
        rst_d[idx_q] = 1'b0;
        state_d      = WAIT_ACK;
        cnt_d        = '0;
      end
      WAIT_ACK: begin
        // A missing ack is treated as a late ack once the timeout expires
        if (ack_c || (cnt_q == TMO_LAST)) begin
          if (!ack_c) begin
            tmo_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = READY;
            ready_d = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = '0;
          end
        end
      end
      GAP: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = RELEASE;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end
      end
      READY: begin
        cnt_d   = cnt_q;
        ready_d = 1'b1;
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase

    // Software re-reset overrides everything, including a same-cycle ack
    if (bus.sw_rst_req_i) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      tmo_d   = 1'b0;
    end

    busy_d = !ready_d;
  end

  assign bus.rst_o       = rst_q;
  assign bus.ready_o     = ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.stage_idx_o = idx_q;
  assign bus.timeout_o   = tmo_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Central reset controller that sequences the reset pins of downstream flops and blocks.
- Takes the raw async active-high reset and produces a synchronized internal reset (async assert, sync deassert).
- Releases NUM_STAGES active-high reset outputs one at a time, in order; each release is gated by the previous stage's ready acknowledge.
- Supports a software-requested full re-reset.
- Sits at the top of each clock domain, next to the clock generator.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; range 1..16.
- HOLD_CYCLES, 8: cycles all outputs stay asserted after the internal reset deasserts; range 1..255.
- STAGE_DELAY, 4: cycles from sampling ack of stage k to release of stage k+1; range 1..255.
- ACK_TIMEOUT, 16: max cycles to wait for a stage ack before forcing progress; range 1..255.

Ports:
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset; asserts every output immediately.
- sw_rst_req_i  input  1  single-cycle request to re-run the full sequence.
- stage_ack_i  input  NUM_STAGES  per-stage ready acknowledge, level-sensitive.
- rst_o  output  NUM_STAGES  active-high reset to stage k; released in index order 0..NUM_STAGES-1.
- ready_o  output  1  high once all stages are released and acknowledged.
- busy_o  output  1  equals !ready_o.
- stage_idx_o  output  $clog2(NUM_STAGES) (min 1)  stage currently being released or awaited.
- timeout_o  output  1  sticky flag: at least one stage ack timed out.

Behaviour:
- Synchronizer:
  - rst_sync is set asynchronously by reset.
  - rst_sync clears on the 2nd rising clk edge after reset deasserts.
  - All sequencer flops use rst_sync as their async reset.
- Reset values (reset or rst_sync high): rst_o all ones, ready_o=0, busy_o=1, stage_idx_o=0, timeout_o=0, state=HOLD, counter=0.
- FSM states: HOLD, RELEASE, WAIT_ACK, GAP, READY.
- HOLD:
  - counter increments each cycle.
  - When counter==HOLD_CYCLES-1: go to RELEASE, clear counter, stage_idx=0.
  - Result: rst_o[0] falls exactly 2+HOLD_CYCLES edges after reset deasserts.
- RELEASE: clear rst_o[stage_idx]; go to WAIT_ACK; clear counter. This takes one cycle, with the register update at the edge leaving RELEASE.
- WAIT_ACK:
  - Sample stage_ack_i[stage_idx] each cycle; counter increments.
  - If ack=1: if this is the last stage, go to READY; otherwise go to GAP and clear counter.
  - If ack=0 and counter==ACK_TIMEOUT-1: set timeout_o and proceed exactly as if ack=1.
- GAP:
  - counter increments.
  - When counter==STAGE_DELAY-1: increment stage_idx and go to RELEASE.
  - Total: ack sampled at edge E gives rst_o[k+1] falling at edge E+STAGE_DELAY+1.
- READY: ready_o=1, busy_o=0. stage_idx_o holds NUM_STAGES-1.
- sw_rst_req_i (any state):
  - Next edge: rst_o all ones, ready_o=0, timeout_o cleared, stage_idx=0, counter=0, state=HOLD.
  - The synchronizer is not involved.
  - A request during sequencing restarts from HOLD.
- Monotonic release: once cleared, an rst_o bit stays low until reset or sw_rst_req_i. Acks for already-released or not-yet-released stages are ignored.
- Ack already high on entry to WAIT_ACK is accepted on the first WAIT_ACK cycle.
- Reset mid-operation: all rst_o assert asynchronously in the same cycle; the sequence restarts after synchronization.
- Counter: 8 bits, saturating never required because every compare bound is ≤255.

Decomposition:
- Package reset_seq_pkg: state enum (HOLD, RELEASE, WAIT_ACK, GAP, READY), CNT_W=8 constant, parameter-range check function.
- Sub-module reset_sync: 2-flop async-assert / sync-deassert synchronizer, ports clk, reset, rst_sync_o.
- Everything else is single-module FSM plus counter.

Test Plan:
Test configuration: NUM_STAGES=4, HOLD_CYCLES=8, STAGE_DELAY=4, ACK_TIMEOUT=16.
1. Reset deasserts before edge 0, all acks tied high -> rst_o[0] falls at edge 10, rst_o[1] at 16, rst_o[2] at 22, rst_o[3] at 28, ready_o rises at 29; no timeout.
2. stage_ack_i[2] held low -> after rst_o[2] falls, 16 WAIT_ACK cycles pass, then timeout_o=1 and rst_o[3] falls 5 edges later; ready_o eventually 1 with timeout_o still 1.
3. sw_rst_req_i pulse in READY -> next edge rst_o=4'hF, ready_o=0, timeout_o=0; rst_o[0] falls exactly 9 edges after the request edge (HOLD plus RELEASE).
4. reset pulsed mid-WAIT_ACK on stage 1 -> rst_o=4'hF asynchronously in the same cycle without waiting for clk; full sequence repeats with the scenario 1 timing.
5. Ack on stage 3 asserted early (during stage 0 wait), then dropped before stage 3 -> no effect on order; stage 3 waits for its own ack or times out.
6. sw_rst_req_i and stage_ack_i[1] both high in the same cycle of WAIT_ACK -> request wins: state HOLD, stage_idx_o=0, rst_o=4'hF.
